instr_cache_mt: RTL and testbench

//  Multithreaded instruction cache between the iTLB and the memory hierarchy in fetch.

---
 rtl/soc_pkg.sv | 24 ++
 rtl/icache_victim_sel.sv | 28 ++
 rtl/instr_cache_mt.sv | 119 +++++++++++
 tb/tb_instr_cache_mt.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// soc_pkg: shared SoC constants and types for the fetch-side instruction cache
//   THR_PER_CORE / THR_W     hardware threads and thread-id width
//   PHY_ADDR_W / LINE_W      physical address and cache line widths
//   ICACHE_NUM_LINES         fully associative line count
//   multithreading_mode_t    Single_Threaded | Multi_Threaded
//   memory_request_t         {addr, is_store, data} sent to the memory hierarchy
package soc_pkg;
    localparam int THR_PER_CORE     = 4;
    localparam int THR_W            = $clog2(THR_PER_CORE);
    localparam int PHY_ADDR_W       = 20;
    localparam int LINE_W           = 128;
    localparam int ICACHE_NUM_LINES = 4;

    typedef enum logic {
        Single_Threaded,
        Multi_Threaded
    } multithreading_mode_t;

    typedef struct packed {
        logic [PHY_ADDR_W-1:0] addr;
        logic                  is_store;
        logic [LINE_W-1:0]     data;
    } memory_request_t;
endpackage

// File: rtl/icache_victim_sel.sv
// icache_victim_sel: picks the line a fill writes into
//   valid_vec  in   per-line valid bits
//   match_vec  in   per-line "valid and tag equals fill tag"
//   ptr        in   round-robin victim pointer
//   tgt        out  target line index
//   adv        out  a valid line is being evicted, so the pointer must advance
module icache_victim_sel
    import soc_pkg::*;
#(
    parameter int N  = ICACHE_NUM_LINES,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  valid_vec,
    input  logic [N-1:0]  match_vec,
    input  logic [LW-1:0] ptr,
    output logic [LW-1:0] tgt,
    output logic          adv
);
    // Priority: matching line (no duplicates) > lowest invalid line > pointer.
    always_comb begin
        tgt = ptr;
        adv = (&valid_vec) && !(|match_vec);
        for (int i = N - 1; i >= 0; i--)
            if (!valid_vec[i]) tgt = LW'(i);
        for (int i = 0; i < N; i++)
            if (match_vec[i]) tgt = LW'(i);
    end
endmodule

// File: rtl/instr_cache_mt.sv
// instr_cache_mt: multithreaded fully associative instruction cache
//   clock, reset (sync, active-low)
//   mt_mode                                   threading mode
//   req_valid/req_addr/req_thread_id          lookup request
//   rsp_valid/rsp_data                        same-cycle hit or bypass line
//   icache_ready                              per-thread "no outstanding miss"
//   xcpt_bus_error                            fill came back with a bus error
//   req_valid_miss/req_info_miss              line-fill request
//   rsp_valid_miss/rsp_thread_id/
//   rsp_data_miss/rsp_bus_error               fill response
module instr_cache_mt
    import soc_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  multithreading_mode_t    mt_mode,
    input  logic                    req_valid,
    input  logic [PHY_ADDR_W-1:0]   req_addr,
    input  logic [THR_W-1:0]        req_thread_id,
    output logic                    rsp_valid,
    output logic [LINE_W-1:0]       rsp_data,
    output logic [THR_PER_CORE-1:0] icache_ready,
    output logic                    xcpt_bus_error,
    output logic                    req_valid_miss,
    output memory_request_t         req_info_miss,
    input  logic                    rsp_valid_miss,
    input  logic [THR_W-1:0]        rsp_thread_id,
    input  logic [LINE_W-1:0]       rsp_data_miss,
    input  logic                    rsp_bus_error
);
    localparam int N     = ICACHE_NUM_LINES;
    localparam int LW    = $clog2(N);
    localparam int TAG_W = PHY_ADDR_W - 4;

    logic [N-1:0]            valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q [N];
    logic [TAG_W-1:0]        tag_d [N];
    logic [LINE_W-1:0]       data_q [N];
    logic [LINE_W-1:0]       data_d [N];
    logic [LW-1:0]           ptr_q, ptr_d;
    logic [THR_PER_CORE-1:0] pend_q, pend_d;
    // Tag each thread is waiting on; the fill response carries no address.
    logic [TAG_W-1:0]        ptag_q [THR_PER_CORE];
    logic [TAG_W-1:0]        ptag_d [THR_PER_CORE];

    logic [THR_W-1:0] tid;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic [N-1:0]     hit_vec, fill_match;
    logic [LW-1:0]    hit_idx, tgt;
    logic             accept, hit, bypass, miss, fill, fill_wr, adv;

    icache_victim_sel #(.N(N), .LW(LW)) u_victim_sel (
        .valid_vec(valid_q),
        .match_vec(fill_match),
        .ptr      (ptr_q),
        .tgt      (tgt),
        .adv      (adv)
    );

    always_comb begin
        tid      = mt_mode == Single_Threaded ? '0 : req_thread_id;
        req_tag  = req_addr[PHY_ADDR_W-1:4];
        fill_tag = ptag_q[rsp_thread_id];
        for (int t = 0; t < THR_PER_CORE; t++)
            icache_ready[t] = !pend_q[t] && (mt_mode == Multi_Threaded || t == 0);
        accept  = req_valid && icache_ready[tid];
        hit_idx = '0;
        for (int i = 0; i < N; i++) begin
            hit_vec[i]    = valid_q[i] && tag_q[i] == req_tag;
            fill_match[i] = valid_q[i] && tag_q[i] == fill_tag;
            if (hit_vec[i]) hit_idx = LW'(i);
        end
        hit            = accept && |hit_vec;
        bypass         = accept && !hit && rsp_valid_miss && rsp_thread_id == tid && !rsp_bus_error;
        miss           = accept && !hit && !bypass;
        fill           = rsp_valid_miss && pend_q[rsp_thread_id];
        fill_wr        = fill && !rsp_bus_error;
        xcpt_bus_error = fill && rsp_bus_error;
        rsp_valid      = hit || bypass;
        rsp_data       = hit ? data_q[hit_idx] : bypass ? rsp_data_miss : '0;
        req_valid_miss = miss;
        req_info_miss  = '{addr: {req_tag, 4'b0}, is_store: 1'b0, data: '0};
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        ptag_d  = ptag_q;
        if (fill) pend_d[rsp_thread_id] = 1'b0;
        if (fill_wr) begin
            valid_d[tgt] = 1'b1;
            tag_d[tgt]   = fill_tag;
            data_d[tgt]  = rsp_data_miss;
            if (adv) ptr_d = ptr_q == LW'(N - 1) ? '0 : ptr_q + LW'(1);
        end
        if (miss) begin
            pend_d[tid] = 1'b1;
            ptag_d[tid] = req_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= '0;
            tag_q   <= '{default: '0};
            data_q  <= '{default: '0};
            ptr_q   <= '0;
            pend_q  <= '0;
            ptag_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            ptag_q  <= ptag_d;
        end
    end
endmodule

// File: tb/tb_instr_cache_mt.sv
// tb_instr_cache_mt: directed scenarios plus randomized traffic against a line-level cache model
module tb_instr_cache_mt;
    import soc_pkg::*;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    multithreading_mode_t    mt_mode = Multi_Threaded;
    logic                    req_valid = 1'b0;
    logic [PHY_ADDR_W-1:0]   req_addr = '0;
    logic [THR_W-1:0]        req_thread_id = '0;
    logic                    rsp_valid;
    logic [LINE_W-1:0]       rsp_data;
    logic [THR_PER_CORE-1:0] icache_ready;
    logic                    xcpt_bus_error;
    logic                    req_valid_miss;
    memory_request_t         req_info_miss;
    logic                    rsp_valid_miss = 1'b0;
    logic [THR_W-1:0]        rsp_thread_id = '0;
    logic [LINE_W-1:0]       rsp_data_miss = '0;
    logic                    rsp_bus_error = 1'b0;

    instr_cache_mt dut (
        .clock         (clock),
        .reset         (reset),
        .mt_mode       (mt_mode),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_thread_id (req_thread_id),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .icache_ready  (icache_ready),
        .xcpt_bus_error(xcpt_bus_error),
        .req_valid_miss(req_valid_miss),
        .req_info_miss (req_info_miss),
        .rsp_valid_miss(rsp_valid_miss),
        .rsp_thread_id (rsp_thread_id),
        .rsp_data_miss (rsp_data_miss),
        .rsp_bus_error (rsp_bus_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: a set of resident lines with tags, FIFO replacement, per-thread waits.
    bit          m_valid [ICACHE_NUM_LINES];
    logic [15:0] m_tag   [ICACHE_NUM_LINES];
    logic [127:0] m_data [ICACHE_NUM_LINES];
    int          m_ptr;
    bit          m_pend  [THR_PER_CORE];
    logic [15:0] m_ptag  [THR_PER_CORE];

    task automatic check(string tag, logic [LINE_W-1:0] got, logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ICACHE_NUM_LINES; i++) m_valid[i] = 0;
        for (int t = 0; t < THR_PER_CORE; t++) m_pend[t] = 0;
        m_ptr = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        req_valid = 1'b0;
        rsp_valid_miss = 1'b0;
        @(posedge clock);
        model_clear();
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic step(bit rv, logic [19:0] a, int t, bit mv, int mt, logic [127:0] md, bit me);
        int tid, hit, tgt;
        bit acc, byp, miss, fill, found;
        logic [3:0] e_ready;
        logic [127:0] e_data;
        @(negedge clock);
        reset = 1'b1;
        req_valid = rv;
        req_addr = a;
        req_thread_id = THR_W'(t);
        rsp_valid_miss = mv;
        rsp_thread_id = THR_W'(mt);
        rsp_data_miss = md;
        rsp_bus_error = me;
        #1;
        tid = (mt_mode == Single_Threaded) ? 0 : t;
        for (int k = 0; k < THR_PER_CORE; k++)
            e_ready[k] = !m_pend[k] && (mt_mode == Multi_Threaded || k == 0);
        acc = rv && e_ready[tid];
        hit = -1;
        for (int i = 0; i < ICACHE_NUM_LINES; i++)
            if (m_valid[i] && m_tag[i] == a[19:4]) hit = i;
        byp = acc && hit < 0 && mv && mt == tid && !me;
        miss = acc && hit < 0 && !byp;
        fill = mv && m_pend[mt];
        e_data = !acc ? 128'd0 : hit >= 0 ? m_data[hit] : byp ? md : 128'd0;
        check("ready", icache_ready, e_ready);
        check("rsp_valid", rsp_valid, acc && (hit >= 0 || byp));
        check("rsp_data", rsp_data, e_data);
        check("miss_req", req_valid_miss, miss);
        check("xcpt", xcpt_bus_error, fill && me);
        if (miss) begin
            check("miss_addr", req_info_miss.addr, {a[19:4], 4'b0});
            check("miss_store_data", {req_info_miss.is_store, req_info_miss.data}, 0);
        end
        if (fill) begin
            m_pend[mt] = 0;
            if (!me) begin
                found = 0;
                tgt = m_ptr;
                for (int i = 0; i < ICACHE_NUM_LINES; i++)
                    if (!found && m_valid[i] && m_tag[i] == m_ptag[mt]) begin tgt = i; found = 1; end
                for (int i = 0; i < ICACHE_NUM_LINES; i++)
                    if (!found && !m_valid[i]) begin tgt = i; found = 1; end
                if (!found) m_ptr = (m_ptr + 1) % ICACHE_NUM_LINES;
                m_valid[tgt] = 1;
                m_tag[tgt] = m_ptag[mt];
                m_data[tgt] = md;
            end
        end
        if (miss) begin
            m_pend[tid] = 1;
            m_ptag[tid] = a[19:4];
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill_line(int t, logic [19:0] a, logic [127:0] d);
        step(1, a, t, 0, 0, 0, 0);
        step(0, 0, 0, 1, t, d, 0);
    endtask

    logic [127:0] dat_a, dat_b, dat_c, rnd;
    int r;

    initial begin
        dat_a = {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004};
        dat_b = {4{32'hBBBB_5555}};
        dat_c = {4{32'hCCCC_3333}};
        do_reset();
        #1;
        check("reset_ready", icache_ready, 4'b1111);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_miss", req_valid_miss, 0);

        // 1: first miss
        step(1, 20'h00104, 0, 0, 0, 0, 0);
        check("t1_miss", req_valid_miss, 1);
        check("t1_addr", req_info_miss.addr, 20'h00100);
        idle();
        check("t1_ready", icache_ready, 4'b1110);

        // 2: fill, then same-cycle hit
        step(0, 0, 0, 1, 0, dat_a, 0);
        step(1, 20'h0010C, 0, 0, 0, 0, 0);
        check("t2_ready", icache_ready, 4'b1111);
        check("t2_hit_data", rsp_data, dat_a);

        // 3: overlapping misses, other thread still hits
        step(1, 20'h00400, 0, 0, 0, 0, 0);
        step(1, 20'h00200, 1, 0, 0, 0, 0);
        step(1, 20'h00108, 2, 0, 0, 0, 0);
        check("t3_t2_hit", rsp_valid, 1);
        check("t3_ready", icache_ready, 4'b1100);
        step(0, 0, 0, 1, 1, dat_b, 0);
        step(0, 0, 0, 1, 0, dat_c, 0);
        step(1, 20'h00200, 3, 0, 0, 0, 0);
        check("t3_line200", rsp_data, dat_b);
        step(1, 20'h00404, 3, 0, 0, 0, 0);
        check("t3_line400", rsp_data, dat_c);

        // 4: bus error, no fill
        step(1, 20'h00300, 2, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2, dat_a, 1);
        check("t4_xcpt", xcpt_bus_error, 1);
        step(1, 20'h00300, 2, 0, 0, 0, 0);
        check("t4_ready_and_remiss", {icache_ready[2], req_valid_miss}, 2'b11);
        step(0, 0, 0, 1, 2, dat_a, 0);

        // bypass: response for a non-pending thread forwards the data
        step(1, 20'h00900, 3, 1, 3, dat_b, 0);
        check("bypass", {rsp_valid, rsp_data}, {1'b1, dat_b});

        // 5: replacement
        do_reset();
        for (int k = 1; k <= 5; k++) fill_line(0, 20'(k * 32'h1000), {4{32'(k)}});
        step(1, 20'h01000, 1, 0, 0, 0, 0);
        check("t5_evicted_miss", req_valid_miss, 1);
        step(1, 20'h02000, 2, 0, 0, 0, 0);
        check("t5_kept_hit", rsp_data, {4{32'd2}});
        step(1, 20'h05000, 3, 0, 0, 0, 0);
        check("t5_new_hit", rsp_data, {4{32'd5}});

        // 6: single-threaded
        do_reset();
        mt_mode = Single_Threaded;
        step(1, 20'h00700, 3, 0, 0, 0, 0);
        check("t6_ready", {icache_ready, req_valid_miss}, 5'b00011);
        step(1, 20'h00700, 0, 0, 0, 0, 0);
        check("t6_ignored", {rsp_valid, req_valid_miss}, 2'b00);
        do_reset();
        idle();
        check("t6_reset_ready", icache_ready, 4'b0001);
        step(0, 0, 0, 1, 0, dat_a, 1);
        check("t6_late_ignored", xcpt_bus_error, 0);
        step(1, 20'h00700, 2, 0, 0, 0, 0);
        check("t6_still_miss", req_valid_miss, 1);

        // Randomized traffic, both modes
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            mt_mode = pass == 0 ? Multi_Threaded : Single_Threaded;
            for (int n = 0; n < 800; n++) begin
                r = $urandom_range(0, 3);
                rnd = {$urandom, $urandom, $urandom, $urandom};
                if (m_pend[r] && $urandom_range(0, 2) == 0)
                    step($urandom_range(0, 1), 20'(32'h100 * $urandom_range(1, 6) + $urandom_range(0, 15)),
                         $urandom_range(0, 3), 1, r, rnd, $urandom_range(0, 7) == 0);
                else
                    step($urandom_range(0, 1), 20'(32'h100 * $urandom_range(1, 6) + $urandom_range(0, 15)),
                         $urandom_range(0, 3), 0, r, rnd, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
